// File: rtl/prog_loader.sv
// prog_loader: writer side of the program memory.
// Receives a framed byte stream (HEADER, LEN, LEN data bytes, CSUM) and writes
// the data bytes into the program memory write port. It holds the CPU in reset
// while a frame is being loaded and reports framing and checksum errors.
//
// Ports:
//   clk        system clock, all state on posedge
//   rst_n      asynchronous active-low reset
//   in_data    stream byte
//   in_valid   in_data valid; a byte is accepted when in_valid && in_ready
//   in_ready   the block can accept a byte this cycle
//   abort      cancel the frame in progress
//   mem_we     program memory write strobe, one cycle per data byte
//   mem_addr   program memory write address
//   mem_wdata  program memory write data
//   cpu_hold   1 = keep the CPU in reset
//   done       one-cycle pulse: frame loaded and checksum good
//   err        one-cycle pulse: frame rejected
//   err_code   last error: 00 none, 01 bad length, 10 checksum, 11 timeout/abort
//   prog_len   byte count of the last good frame
module prog_loader #(
  parameter int          ADDR_W  = 4,
  parameter logic [7:0]  HEADER  = 8'hA5,
  parameter int          TIMEOUT = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              abort,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   prog_len
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int TW    = $clog2(TIMEOUT + 1);
  // Expiry fires on the cycle the counter would reach TIMEOUT.
  localparam logic [TW-1:0] TOUT_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [7:0]        sum_q, sum_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic [1:0]        err_code_q, err_code_d;
  logic [ADDR_W:0]   prog_len_q, prog_len_d;

  logic              accept;
  logic              len_ok;
  logic              csum_ok;
  logic [ADDR_W:0]   cnt_inc;
  logic [7:0]        sum_add;

  assign in_ready = ((state_q == S_IDLE) || (state_q == S_LEN) ||
                     (state_q == S_DATA) || (state_q == S_CSUM)) && !abort;
  assign accept   = in_valid && in_ready;

  // Length is compared at 32 bits so LEN == DEPTH works for any ADDR_W.
  assign len_ok   = ({24'd0, in_data} >= 32'd1) && ({24'd0, in_data} <= DEPTH);
  assign sum_add  = sum_q + in_data;
  assign csum_ok  = (sum_add == 8'h00);
  // cnt is one bit wider than the address so LEN == DEPTH does not wrap.
  assign cnt_inc  = cnt_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    sum_d       = sum_q;
    tcnt_d      = '0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_hold_d  = cpu_hold_q;
    err_code_d  = err_code_q;
    prog_len_d  = prog_len_q;

    case (state_q)
      S_IDLE: begin
        if (accept && (in_data == HEADER)) begin
          state_d    = S_LEN;
          cpu_hold_d = 1'b1;
        end
      end

      S_LEN, S_DATA, S_CSUM: begin
        if (abort) begin
          state_d    = S_ERR;
          err_code_d = 2'b11;
        end else if (accept) begin
          // An accepted byte always beats a simultaneous timeout expiry.
          case (state_q)
            S_LEN: begin
              if (len_ok) begin
                state_d = S_DATA;
                cnt_d   = '0;
                sum_d   = in_data;
                len_d   = (ADDR_W + 1)'(in_data);
              end else begin
                state_d    = S_ERR;
                err_code_d = 2'b01;
              end
            end
            S_DATA: begin
              sum_d       = sum_add;
              mem_we_d    = 1'b1;
              mem_addr_d  = cnt_q[ADDR_W-1:0];
              mem_wdata_d = in_data;
              cnt_d       = cnt_inc;
              if (cnt_inc == len_q) begin
                state_d = S_CSUM;
              end
            end
            default: begin
              if (csum_ok) begin
                state_d    = S_DONE;
                prog_len_d = len_q;
                err_code_d = 2'b00;
                cpu_hold_d = 1'b0;
              end else begin
                state_d    = S_ERR;
                err_code_d = 2'b10;
              end
            end
          endcase
        end else if (tcnt_q == TOUT_LAST) begin
          state_d    = S_ERR;
          err_code_d = 2'b11;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end

      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      len_q       <= '0;
      sum_q       <= '0;
      tcnt_q      <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_hold_q  <= 1'b0;
      err_code_q  <= 2'b00;
      prog_len_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      sum_q       <= sum_d;
      tcnt_q      <= tcnt_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_hold_q  <= cpu_hold_d;
      err_code_q  <= err_code_d;
      prog_len_q  <= prog_len_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_hold  = cpu_hold_q;
  assign err_code  = err_code_q;
  assign prog_len  = prog_len_q;
  assign done      = (state_q == S_DONE);
  assign err       = (state_q == S_ERR);

endmodule
